sar_channel_sequencer: RTL and testbench

- Multi-channel scan controller for the sar_adc_digital core.
- Walks an enabled-channel mask round-robin and drives the analog mux select and sample/hold enable.
- Starts each conversion by pulsing the SAR core's reset input, waits for the core's done, then presents the tagged result on a valid/ready output.
- Sits between the SAR digital core and the system/register side.

---
 rtl/sar_channel_sequencer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_sar_channel_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_channel_sequencer.sv
// ============================================================================
// sar_channel_sequencer
// ----------------------------------------------------------------------------
// Multi-channel scan controller for the sar_adc_digital core. Walks the
// enabled-channel mask round-robin. For each channel it drives the analog mux
// select and closes the sample/hold switch. It then starts a conversion by
// pulsing the SAR core's reset input, waits for the core's done, and presents
// the channel-tagged result on a valid/ready output register.
//
// Scan sequence per channel:
//   SETTLE (1) -> SAMPLE (SAMPLE_CYCLES) -> START (1) -> CONVERT -> STORE
//
// Ports:
//   clk           in   system clock, all state on the rising edge
//   reset         in   asynchronous active-high reset
//   enable        in   scan enable (level)
//   ch_mask       in   [NUM_CH]  channel enable mask, bit i = scan channel i
//   mux_sel       out  [CHW]     analog mux channel select
//   sample_en     out  sample/hold switch closed while high
//   sar_restart   out  1-cycle pulse into the SAR core reset starts a conversion
//   sar_done      in   SAR core done
//   sar_data      in   [SIZE]    SAR core digital_out
//   result_valid  out  result register holds an unread result
//   result_ready  in   consumer accepts the result when high with result_valid
//   result_ch     out  [CHW]     channel index of the held result
//   result_data   out  [SIZE]    held conversion code
//   busy          out  high whenever the sequencer is not idle
//   timeout_err   out  sticky conversion-timeout flag
//
// Build option:
//   SAR_TIMEOUT_EN - when defined, a CONVERT that sees no sar_done within
//   TIMEOUT_CYCLES cycles is abandoned. The conversion is discarded,
//   timeout_err is set until reset, and the scan moves on. When undefined,
//   CONVERT waits for sar_done indefinitely and timeout_err is tied low.
// ============================================================================
module sar_channel_sequencer #(
    parameter  int NUM_CH         = 4,
    parameter  int SIZE           = 4,
    parameter  int SAMPLE_CYCLES  = 2,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int CHW            = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [CHW-1:0]    mux_sel,
    output logic              sample_en,
    output logic              sar_restart,
    input  logic              sar_done,
    input  logic [SIZE-1:0]   sar_data,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [CHW-1:0]    result_ch,
    output logic [SIZE-1:0]   result_data,
    output logic              busy,
    output logic              timeout_err
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------------
    if (NUM_CH < 2 || NUM_CH > 16 || SIZE < 1 || SAMPLE_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("sar_channel_sequencer: illegal parameter value");
    end

    localparam int SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_START,
        S_CONVERT,
        S_STORE
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t            r_state;
    logic [CHW-1:0]    r_ptr;          // last channel selected
    logic [CHW-1:0]    r_mux_sel;
    logic [SCW-1:0]    r_sample_cnt;   // remaining SAMPLE cycles minus one
    logic              r_conv_first;   // high during the first CONVERT cycle
    logic              r_result_valid;
    logic [CHW-1:0]    r_result_ch;
    logic [SIZE-1:0]   r_result_data;
`ifdef SAR_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TCW-1:0]    r_timeout_cnt;  // CONVERT cycles already elapsed
    logic              r_timeout_err;
    logic              w_timeout;
`endif

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    state_t            w_state_next;
    logic [CHW-1:0]    w_next_ch;
    logic              w_found;
    logic              w_go;
    logic              w_advance;
    logic              w_select;
    logic              w_capture;
    logic              w_can_store;

    // ------------------------------------------------------------------------
    // Next-channel search: first set mask bit strictly after the pointer,
    // wrapping modulo NUM_CH. The last candidate is the pointer itself, so a
    // single set bit re-selects the same channel.
    // ------------------------------------------------------------------------
    always_comb begin
        logic [CHW:0]   v_sum;
        logic [CHW-1:0] v_idx;
        // NOTE: every variable gets a default before any conditional
        // assignment, so no path through the block can infer a latch.
        w_next_ch = r_ptr;
        w_found   = 1'b0;
        v_sum     = '0;
        v_idx     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            v_sum = {1'b0, r_ptr} + (CHW+1)'(k);
            if (v_sum >= (CHW+1)'(NUM_CH)) begin
                v_sum = v_sum - (CHW+1)'(NUM_CH);
            end
            v_idx = v_sum[CHW-1:0];
            if (!w_found && ch_mask[v_idx]) begin
                w_found   = 1'b1;
                w_next_ch = v_idx;
            end
        end
    end

    assign w_go        = enable && w_found;
    assign w_can_store = !r_result_valid || result_ready;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        w_select     = 1'b0;
        w_capture    = 1'b0;
`ifdef SAR_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            // Leaving IDLE follows the same rule as advancing after a
            // conversion: go on if there is something to scan, else idle.
            S_IDLE:   w_advance = 1'b1;
            S_SETTLE: w_state_next = S_SAMPLE;
            S_SAMPLE: begin
                if (r_sample_cnt == '0) begin
                    w_state_next = S_START;
                end
            end
            S_START:  w_state_next = S_CONVERT;
            S_CONVERT: begin
                // The core's done may still be high from the previous
                // conversion during the first cycle after the restart pulse.
                if (!r_conv_first && sar_done) begin
                    w_state_next = S_STORE;
                end
`ifdef SAR_TIMEOUT_EN
                else if (r_timeout_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout = 1'b1;
                    w_advance = 1'b1;
                end
`endif
            end
            S_STORE: begin
                // Stall until the output register is free; nothing is dropped.
                if (w_can_store) begin
                    w_capture = 1'b1;
                    w_advance = 1'b1;
                end
            end
            default:  w_state_next = S_IDLE;
        endcase

        if (w_advance) begin
            w_select     = w_go;
            w_state_next = w_go ? S_SETTLE : S_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // The pointer starts at the top channel so the first search
            // wraps around and picks the lowest set bit.
            r_ptr          <= CHW'(NUM_CH - 1);
            r_mux_sel      <= '0;
            r_sample_cnt   <= '0;
            r_conv_first   <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_ch    <= '0;
            r_result_data  <= '0;
        end else begin
            // mux_sel changes only on a channel decision, so it holds in IDLE.
            if (w_select) begin
                r_ptr     <= w_next_ch;
                r_mux_sel <= w_next_ch;
            end

            if (r_state == S_SETTLE) begin
                r_sample_cnt <= SCW'(SAMPLE_CYCLES - 1);
            end else if (r_state == S_SAMPLE && r_sample_cnt != '0) begin
                r_sample_cnt <= r_sample_cnt - 1'b1;
            end

            r_conv_first <= (r_state == S_START);

            // A capture in the same cycle as a handshake keeps valid high
            // with the new data.
            if (w_capture) begin
                r_result_valid <= 1'b1;
                r_result_ch    <= r_mux_sel;
                r_result_data  <= sar_data;
            end else if (r_result_valid && result_ready) begin
                r_result_valid <= 1'b0;
            end
        end
    end

`ifdef SAR_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout_cnt <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_START) begin
                r_timeout_cnt <= '0;
            end else if (r_state == S_CONVERT) begin
                r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mux_sel      = r_mux_sel;
    assign sample_en    = (r_state == S_SAMPLE);
    assign sar_restart  = (r_state == S_START);
    assign busy         = (r_state != S_IDLE);
    assign result_valid = r_result_valid;
    assign result_ch    = r_result_ch;
    assign result_data  = r_result_data;

endmodule

// File: tb/tb_sar_channel_sequencer.sv
// ============================================================================
// tb_sar_channel_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for sar_channel_sequencer (NUM_CH=4, SIZE=4). A
// behavioural SAR core answers every restart with code 4'hA + channel, with
// done arriving at the nominal time. Its done stays stale-high into the first
// cycle after a restart. A table of channel masks is scanned with hand-derived
// expected channel orders. Hand-written sequences cover back-pressure, empty
// mask, enable drop, async reset, single-channel timing and (with
// SAR_TIMEOUT_EN) the conversion timeout.
// ============================================================================
module tb_sar_channel_sequencer;

    localparam int NUM_CH = 4;
    localparam int SIZE   = 4;
    localparam int CHW    = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic [CHW-1:0]    mux_sel;
    logic              sample_en;
    logic              sar_restart;
    logic              sar_done;
    logic [SIZE-1:0]   sar_data;
    logic              result_valid;
    logic              result_ready = 1'b1;
    logic [CHW-1:0]    result_ch;
    logic [SIZE-1:0]   result_data;
    logic              busy;
    logic              timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sar_channel_sequencer #(
        .NUM_CH        (NUM_CH),
        .SIZE          (SIZE),
        .SAMPLE_CYCLES (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .ch_mask     (ch_mask),
        .mux_sel     (mux_sel),
        .sample_en   (sample_en),
        .sar_restart (sar_restart),
        .sar_done    (sar_done),
        .sar_data    (sar_data),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_ch   (result_ch),
        .result_data (result_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // ------------------------------------------------------------------------
    // Behavioural SAR core. Starts with a stale done and a bogus code so a
    // sequencer that trusts the first CONVERT cycle stores the wrong value.
    // ------------------------------------------------------------------------
    logic            m_done = 1'b1;
    logic [SIZE-1:0] m_data = 4'h5;
    logic            m_active = 1'b0;
    logic            m_hang = 1'b0;
    int              m_cnt = 0;

    always @(posedge clk) begin
        if (sar_restart) begin
            m_active <= 1'b1;
            m_cnt    <= 0;
        end else if (m_active) begin
            m_cnt <= m_cnt + 1;
            if (!m_hang && (m_cnt + 1) >= SIZE) begin
                m_done <= 1'b1;
                m_data <= 4'hA + {2'b00, mux_sel};
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    assign sar_done = m_done;
    assign sar_data = m_data;

    // ------------------------------------------------------------------------
    // Pulse-width monitor for sample_en and sar_restart
    // ------------------------------------------------------------------------
    int se_run = 0, rs_run = 0;
    int se_bad = 0, rs_bad = 0;
    int se_pulses = 0, rs_pulses = 0;

    always @(negedge clk) begin
        if (reset) begin
            se_run = 0;
            rs_run = 0;
        end else begin
            if (sample_en) se_run++;
            else if (se_run != 0) begin
                se_pulses++;
                if (se_run != 2) se_bad++;
                se_run = 0;
            end
            if (sar_restart) rs_run++;
            else if (rs_run != 0) begin
                rs_pulses++;
                if (rs_run != 1) rs_bad++;
                rs_run = 0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits for result_valid at a falling edge, bounded by a cycle budget.
    task automatic wait_result(input int budget, output logic [CHW-1:0] ch,
                               output logic [SIZE-1:0] d, output bit ok);
        ok = 1'b0;
        ch = '0;
        d  = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (result_valid) begin
                ch = result_ch;
                d  = result_data;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic expect_result(input string name, input logic [CHW-1:0] exp_ch);
        logic [CHW-1:0]  ch;
        logic [SIZE-1:0] d;
        bit              ok;
        wait_result(100, ch, d, ok);
        check({name, "_arrived"}, 32'(ok), 32'(1));
        check({name, "_ch"}, 32'(ch), 32'(exp_ch));
        check({name, "_data"}, 32'(d), 32'(4'hA + {2'b00, exp_ch}));
    endtask

    // Waits for a sar_restart pulse on a given channel, bounded.
    task automatic wait_restart(input logic [CHW-1:0] ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sar_restart && mux_sel == ch) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
    endtask

    // ------------------------------------------------------------------------
    // Scan vector table: mask and the first three expected result channels
    // ------------------------------------------------------------------------
    typedef struct {
        logic [NUM_CH-1:0]   mask;
        logic [2:0][CHW-1:0] exp_ch;   // exp_ch[0] is the first result
    } scan_vec_t;

    scan_vec_t vecs [7];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit ok;
        int n;
        int rs_base;
        logic [CHW-1:0]  ch;
        logic [SIZE-1:0] d;

        vecs[0] = '{mask: 4'b0101, exp_ch: {2'd0, 2'd2, 2'd0}};
        vecs[1] = '{mask: 4'b1000, exp_ch: {2'd3, 2'd3, 2'd3}};
        vecs[2] = '{mask: 4'b0010, exp_ch: {2'd1, 2'd1, 2'd1}};
        vecs[3] = '{mask: 4'b1111, exp_ch: {2'd2, 2'd1, 2'd0}};
        vecs[4] = '{mask: 4'b1010, exp_ch: {2'd1, 2'd3, 2'd1}};
        vecs[5] = '{mask: 4'b0110, exp_ch: {2'd1, 2'd2, 2'd1}};
        vecs[6] = '{mask: 4'b1001, exp_ch: {2'd0, 2'd3, 2'd0}};

        // ---------------- reset state ----------------
        #1 reset = 1'b1;
        #1;
        check("rst_busy",         32'(busy),         32'(0));
        check("rst_mux_sel",      32'(mux_sel),      32'(0));
        check("rst_sample_en",    32'(sample_en),    32'(0));
        check("rst_sar_restart",  32'(sar_restart),  32'(0));
        check("rst_result_valid", 32'(result_valid), 32'(0));
        check("rst_result_ch",    32'(result_ch),    32'(0));
        check("rst_result_data",  32'(result_data),  32'(0));
        check("rst_timeout_err",  32'(timeout_err),  32'(0));
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table-driven scans ----------------
        for (int v = 0; v < 7; v++) begin
            do_reset();
            ch_mask      = vecs[v].mask;
            result_ready = 1'b1;
            enable       = 1'b1;
            for (int j = 0; j < 3; j++) begin
                expect_result($sformatf("scan%0d_r%0d", v, j), vecs[v].exp_ch[j]);
            end
            enable = 1'b0;
            wait_idle();
        end
        check("sample_en_width_bad",   32'(se_bad), 32'(0));
        check("sar_restart_width_bad", 32'(rs_bad), 32'(0));
        check("sample_en_pulses_seen", 32'(se_pulses >= 21), 32'(1));
        check("sar_restart_pulses_seen", 32'(rs_pulses >= 21), 32'(1));

        // ---------------- back-pressure ----------------
        do_reset();
        rs_base      = rs_pulses;
        ch_mask      = 4'b0101;
        result_ready = 1'b0;
        enable       = 1'b1;
        expect_result("bp_first", 2'd0);
        repeat (40) @(negedge clk);
        check("bp_busy",      32'(busy),         32'(1));
        check("bp_valid",     32'(result_valid), 32'(1));
        check("bp_held_ch",   32'(result_ch),    32'(0));
        check("bp_held_data", 32'(result_data),  32'(4'hA));
        check("bp_sample_en", 32'(sample_en),    32'(0));
        check("bp_restarts",  32'(rs_pulses - rs_base), 32'(2));
        result_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(result_valid), 32'(1));
        check("bp_release_ch",    32'(result_ch),    32'(2));
        check("bp_release_data",  32'(result_data),  32'(4'hC));
        expect_result("bp_after", 2'd0);
        enable = 1'b0;
        wait_idle();

        // ---------------- empty mask / enable drop ----------------
        do_reset();
        rs_base      = rs_pulses;
        ch_mask      = 4'b0000;
        result_ready = 1'b1;
        enable       = 1'b1;
        repeat (30) @(negedge clk);
        check("empty_busy",     32'(busy),                 32'(0));
        check("empty_restarts", 32'(rs_pulses - rs_base),  32'(0));
        check("empty_valid",    32'(result_valid),         32'(0));
        ch_mask = 4'b0101;
        expect_result("drop_first", 2'd0);
        wait_restart(2'd2, ok);
        check("drop_restart_ch2", 32'(ok), 32'(1));
        @(negedge clk);
        enable = 1'b0;
        expect_result("drop_ch2", 2'd2);
        repeat (3) @(negedge clk);
        rs_base = rs_pulses;
        check("drop_idle_busy",    32'(busy),    32'(0));
        check("drop_idle_mux_sel", 32'(mux_sel), 32'(2));
        repeat (20) @(negedge clk);
        check("drop_no_restart",   32'(rs_pulses - rs_base), 32'(0));
        check("drop_mux_hold",     32'(mux_sel), 32'(2));

        // ---------------- async reset mid-CONVERT ----------------
        do_reset();
        ch_mask      = 4'b1111;
        result_ready = 1'b0;
        enable       = 1'b1;
        expect_result("ar_first", 2'd0);
        wait_restart(2'd1, ok);
        check("ar_restart_ch1", 32'(ok), 32'(1));
        @(negedge clk);
        @(negedge clk);
        check("ar_pre_busy",  32'(busy),         32'(1));
        check("ar_pre_valid", 32'(result_valid), 32'(1));
        #2 reset = 1'b1;
        #1;
        check("ar_busy",      32'(busy),         32'(0));
        check("ar_mux_sel",   32'(mux_sel),      32'(0));
        check("ar_valid",     32'(result_valid), 32'(0));
        check("ar_result_ch", 32'(result_ch),    32'(0));
        check("ar_data",      32'(result_data),  32'(0));
        check("ar_sample_en", 32'(sample_en),    32'(0));
        check("ar_restart",   32'(sar_restart),  32'(0));
        @(negedge clk);
        reset        = 1'b0;
        ch_mask      = 4'b1000;
        result_ready = 1'b1;
        expect_result("ar_after_ch3", 2'd3);
        enable = 1'b0;
        wait_idle();

        // ---------------- single channel timing ----------------
        do_reset();
        ch_mask      = 4'b0010;
        result_ready = 1'b1;
        enable       = 1'b1;
        for (int r = 0; r < 2; r++) begin
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (sample_en) begin
                    ok = 1'b1;
                    break;
                end
            end
            check($sformatf("single%0d_sample_seen", r), 32'(ok), 32'(1));
            n = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                n++;
                if (result_valid) break;
            end
            // SAMPLE(2) + START(1) + CONVERT(SIZE+1) after the first SAMPLE
            // cycle plus the capture cycle: valid rises 9 cycles after
            // sample_en rises.
            check($sformatf("single%0d_latency", r), 32'(n), 32'(9));
            check($sformatf("single%0d_ch", r),   32'(result_ch),   32'(1));
            check($sformatf("single%0d_data", r), 32'(result_data), 32'(4'hB));
        end
        enable = 1'b0;
        wait_idle();

`ifdef SAR_TIMEOUT_EN
        // ---------------- conversion timeout ----------------
        do_reset();
        m_hang       = 1'b1;
        ch_mask      = 4'b0101;
        result_ready = 1'b1;
        enable       = 1'b1;
        wait_restart(2'd0, ok);
        check("to_restart_ch0", 32'(ok), 32'(1));
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (timeout_err) break;
        end
        // 16 CONVERT cycles, flag visible in the following cycle.
        check("to_latency",  32'(n),            32'(17));
        check("to_no_valid", 32'(result_valid), 32'(0));
        check("to_next_ch",  32'(mux_sel),      32'(2));
        check("to_busy",     32'(busy),         32'(1));
        m_hang = 1'b0;
        expect_result("to_after_ch2", 2'd2);
        check("to_sticky", 32'(timeout_err), 32'(1));
        enable = 1'b0;
        wait_idle();
`else
        check("no_timeout_flag", 32'(timeout_err), 32'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
